// File: rtl/wordle_scorer.sv
// wordle_scorer: scores a 5-letter guess against the target with duplicate-letter rules.
// Optional hard-mode green-history check enabled by defining WORDLE_SCORER_HARD_MODE_EN.
module wordle_scorer #(
    parameter int WORD_LEN = 5,
    parameter int LETTER_W = 8
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic                         new_game,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] target,
    output logic [2*WORD_LEN-1:0]        result,
    output logic                         win,
    output logic                         bad_guess,
    output logic                         hard_viol,
    output logic                         q_I,
    output logic                         q_Green,
    output logic                         q_Yellow,
    output logic                         q_Done
);
    localparam int JW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [JW-1:0] JLAST = JW'(WORD_LEN - 1);
    localparam logic [LETTER_W-1:0] LA = LETTER_W'(8'h41);
    localparam logic [LETTER_W-1:0] LZ = LETTER_W'(8'h5A);

    typedef enum logic [3:0] {
        QI      = 4'b0001,
        QGREEN  = 4'b0010,
        QYELLOW = 4'b0100,
        QDONE   = 4'b1000
    } state_t;

    state_t state, nxt;
    logic [LETTER_W-1:0] gi [WORD_LEN];
    logic [LETTER_W-1:0] ti [WORD_LEN];
    logic [LETTER_W-1:0] g [WORD_LEN];
    logic [LETTER_W-1:0] t [WORD_LEN];
    logic [1:0] res [WORD_LEN];
    logic [WORD_LEN-1:0] used, greens;
    logic [JW-1:0] j, hit_idx;
    logic bad_in, hit, viol;

    always_comb begin
        for (int i = 0; i < WORD_LEN; i++) begin
            gi[i] = guess[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
            ti[i] = target[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
        end
    end

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < WORD_LEN; i++)
            bad_in = bad_in | (gi[i] < LA) | (gi[i] > LZ);
    end

    // Descending scan so the lowest unconsumed matching index wins
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < WORD_LEN; i++)
            greens[i] = (g[i] == t[i]);
        for (int k = WORD_LEN - 1; k >= 0; k--)
            if (!used[k] && t[k] == g[j]) begin
                hit = 1'b1;
                hit_idx = JW'(k);
            end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < WORD_LEN; i++)
            result[2*(WORD_LEN-1-i) +: 2] = res[i];
    end

`ifdef WORDLE_SCORER_HARD_MODE_EN
    logic [WORD_LEN-1:0] hist_mask, hist_eff;
    logic [LETTER_W-1:0] hist_word [WORD_LEN];

    // A new_game arriving with Start must already see an empty history
    always_comb begin
        hist_eff = (state == QI && new_game) ? '0 : hist_mask;
        viol = 1'b0;
        for (int i = 0; i < WORD_LEN; i++)
            viol = viol | (hist_eff[i] && gi[i] != hist_word[i]);
    end

    always_ff @(posedge Clk) begin
        if (!reset)
            hist_mask <= '0;
        else if (state == QI && new_game)
            hist_mask <= '0;
        else if (state == QDONE && Ack && !bad_guess) begin
            hist_mask <= greens;
            hist_word <= g;
        end
    end
`else
    assign viol = 1'b0 & new_game;
`endif

    always_ff @(posedge Clk) begin
        if (!reset)
            state <= QI;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            QI:      if (Start) nxt = bad_in ? QDONE : QGREEN;
            QGREEN:  nxt = QYELLOW;
            QYELLOW: if (j == JLAST) nxt = QDONE;
            QDONE:   if (Ack) nxt = QI;
            default: nxt = QI;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            for (int i = 0; i < WORD_LEN; i++)
                res[i] <= 2'b00;
            win <= 1'b0;
            bad_guess <= 1'b0;
            hard_viol <= 1'b0;
            j <= '0;
            used <= '0;
        end else begin
            case (state)
                QI: if (Start) begin
                    g <= gi;
                    t <= ti;
                    bad_guess <= bad_in;
                    win <= 1'b0;
                    hard_viol <= viol;
                    for (int i = 0; i < WORD_LEN; i++)
                        res[i] <= 2'b00;
                end
                QGREEN: begin
                    for (int i = 0; i < WORD_LEN; i++)
                        res[i] <= greens[i] ? 2'b10 : 2'b00;
                    used <= greens;
                    j <= '0;
                end
                QYELLOW: begin
                    if (res[j] != 2'b10 && hit) begin
                        res[j] <= 2'b01;
                        used[hit_idx] <= 1'b1;
                    end
                    j <= (j == JLAST) ? j : j + JW'(1);
                    if (j == JLAST)
                        win <= &greens;
                end
                default: ;
            endcase
        end
    end

    assign q_I      = (state == QI);
    assign q_Green  = (state == QGREEN);
    assign q_Yellow = (state == QYELLOW);
    assign q_Done   = (state == QDONE);
endmodule

// File: tb/tb_wordle_scorer.sv
// tb_wordle_scorer: randomized scoreboard bench for wordle_scorer against a letter-count reference model.
module tb_wordle_scorer;
    logic Clk = 1'b0;
    logic reset = 1'b0;
    logic Start = 1'b0;
    logic Ack = 1'b0;
    logic new_game = 1'b0;
    logic [39:0] guess = '0;
    logic [39:0] target = '0;
    logic [9:0] result;
    logic win, bad_guess, hard_viol, q_I, q_Green, q_Yellow, q_Done;

    wordle_scorer dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .new_game(new_game),
        .guess(guess), .target(target), .result(result), .win(win),
        .bad_guess(bad_guess), .hard_viol(hard_viol), .q_I(q_I), .q_Green(q_Green),
        .q_Yellow(q_Yellow), .q_Done(q_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] res;
        logic win;
        logic bad;
        logic hv;
        int start_cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int total = 0;
    int n_bad = 0;
    int cyc = 0;
    logic prev_done = 1'b0;
    logic [4:0] hmask = '0;
    logic [39:0] hword = '0;
    logic [7:0] bad_bytes [5] = '{8'h40, 8'h5B, 8'h61, 8'h00, 8'h34};

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] w(input string s);
        logic [39:0] r = '0;
        for (int i = 0; i < 5; i++) r[(4-i)*8 +: 8] = s[i];
        return r;
    endfunction

    function automatic logic is_bad(input logic [39:0] g);
        for (int i = 0; i < 5; i++)
            if (g[(4-i)*8 +: 8] < 8'h41 || g[(4-i)*8 +: 8] > 8'h5A) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: greens first, then yellows drawn from per-letter counts of unmatched target letters
    function automatic logic [9:0] ref_score(input logic [39:0] g, input logic [39:0] t);
        int cnt [26];
        logic [9:0] r = '0;
        logic [7:0] gl, tl;
        foreach (cnt[k]) cnt[k] = 0;
        for (int i = 0; i < 5; i++) begin
            gl = g[(4-i)*8 +: 8];
            tl = t[(4-i)*8 +: 8];
            if (gl == tl) r[(4-i)*2 +: 2] = 2'b10;
            else cnt[int'(tl) - 65]++;
        end
        for (int i = 0; i < 5; i++) begin
            gl = g[(4-i)*8 +: 8];
            if (r[(4-i)*2 +: 2] != 2'b10 && cnt[int'(gl) - 65] > 0) begin
                r[(4-i)*2 +: 2] = 2'b01;
                cnt[int'(gl) - 65]--;
            end
        end
        return r;
    endfunction

    function automatic logic ref_viol(input logic [39:0] g);
        for (int i = 0; i < 5; i++)
            if (hmask[i] && g[(4-i)*8 +: 8] != hword[(4-i)*8 +: 8]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [39:0] rand_word(input logic allow_bad);
        logic [39:0] r = '0;
        for (int i = 0; i < 5; i++)
            r[(4-i)*8 +: 8] = ($urandom % 4 == 0) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(65, 68));
        if ($urandom % 8 == 0) r[7:0] = 8'h5A;
        if (allow_bad && $urandom % 6 == 0)
            r[(4 - $urandom_range(0, 4))*8 +: 8] = bad_bytes[$urandom_range(0, 4)];
        return r;
    endfunction

    always @(negedge Clk) begin
        if (q_Done && !prev_done) begin
            if (sb.size() == 0) begin
                total++;
                n_bad++;
                $display("FAIL unexpected_done: got q_Done=1 want no pending guess");
            end else begin
                me = sb.pop_front();
                chk("result", 32'(result), 32'(me.res));
                chk("win", 32'(win), 32'(me.win));
                chk("bad_guess", 32'(bad_guess), 32'(me.bad));
                chk("hard_viol", 32'(hard_viol), 32'(me.hv));
                chk("latency", 32'(cyc - me.start_cyc), 32'(me.lat));
            end
        end
        prev_done = q_Done;
    end

    task automatic score(input logic [39:0] g, input logic [39:0] t, input logic ng,
                         input logic dir, input logic [9:0] dres, input logic both);
        exp_t e;
        int n = 0;
        while (!q_I && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_before_start", 32'(q_I), 32'd1);
        guess = g;
        target = t;
        new_game = ng;
        Start = 1'b1;
        if (ng) hmask = '0;
`ifdef WORDLE_SCORER_HARD_MODE_EN
        e.hv = ref_viol(g);
`else
        e.hv = 1'b0;
`endif
        e.bad = is_bad(g);
        e.res = e.bad ? 10'b0 : (dir ? dres : ref_score(g, t));
        e.win = !e.bad && e.res == 10'h2AA;
        e.start_cyc = cyc;
        e.lat = e.bad ? 1 : 7;
        sb.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        new_game = 1'b0;
        guess = {8'($urandom), $urandom};
        target = {8'($urandom), $urandom};
        n = 0;
        while (!q_Done && n < 20) begin
            Start = 1'($urandom_range(0, 1));
            @(negedge Clk);
            n++;
        end
        Start = 1'b0;
        chk("done_reached", 32'(q_Done), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        Ack = 1'b1;
        Start = both;
        @(negedge Clk);
        Ack = 1'b0;
        Start = 1'b0;
        chk("ack_to_idle", 32'(q_I), 32'd1);
        chk("held_result", 32'(result), 32'(e.res));
        if (both) begin
            @(negedge Clk);
            chk("no_queued_start", 32'(q_I), 32'd1);
        end
        if (!e.bad) begin
            for (int i = 0; i < 5; i++) hmask[i] = (e.res[(4-i)*2 +: 2] == 2'b10);
            hword = g;
        end
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("rst_q_I", 32'(q_I), 32'd1);
        chk("rst_busy", 32'({q_Green, q_Yellow, q_Done}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({win, bad_guess, hard_viol}), 32'd0);
        reset = 1'b1;
        @(negedge Clk);

        score(w("CRANE"), w("CRANE"), 1'b1, 1'b1, 10'b1010101010, 1'b0);
        score(w("BABES"), w("ABBEY"), 1'b0, 1'b1, 10'b0101101000, 1'b0);
        score(w("EERIE"), w("CRANE"), 1'b0, 1'b1, 10'b0000010010, 1'b0);
        score(w("CR4NE"), w("CRANE"), 1'b0, 1'b1, 10'b0000000000, 1'b0);
        score(w("AZZZA"), w("ZAAAZ"), 1'b0, 1'b0, 10'b0, 1'b1);

        guess = w("SLATE");
        target = w("CRANE");
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("mid_yellow", 32'(q_Yellow), 32'd1);
        reset = 1'b0;
        @(negedge Clk);
        chk("abort_q_I", 32'(q_I), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_q_Done", 32'(q_Done), 32'd0);
        reset = 1'b1;
        hmask = '0;
        hword = '0;
        score(w("SLATE"), w("CRANE"), 1'b0, 1'b0, 10'b0, 1'b0);

`ifdef WORDLE_SCORER_HARD_MODE_EN
        score(w("CRISP"), w("CRANE"), 1'b1, 1'b0, 10'b0, 1'b0);
        score(w("TRACE"), w("CRANE"), 1'b0, 1'b1, 10'b0010100110, 1'b0);
        score(w("TRACE"), w("CRANE"), 1'b1, 1'b1, 10'b0010100110, 1'b0);
`endif

        for (int k = 0; k < 150; k++)
            score(rand_word(1'b1), rand_word(1'b0), 1'($urandom % 8 == 0), 1'b0, 10'b0,
                  1'($urandom % 10 == 0));

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end
endmodule
